bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Read-side client for one port of the true dual-port BRAM. Drives that port's address, with the write strobe held low, and returns data a contiguous region of memory.
- On a start command, fetches `length` words beginning at `start_addr` and emits them on a valid/ready stream with a last marker.
- Absorbs the RAM's fixed 1-cycle read latency with a 2-entry skid buffer, so downstream backpressure never loses or duplicates a word.
- Typical use: a writer fills the RAM on port A; this block drains it from port B to a UART, DMA or packet engine.

Parameters:
- data_width, 72, RAM word width; matches the RAM instance.
- address_width, 10, RAM address width.
- ram_size, 512, number of words; address wrap point.
- len_width, address_width+1, width of the length field; allows a full-RAM transfer.

Ports:
- clk  in  1  single clock; same clock as the RAM port it drives.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe; ignored while busy=1.
- start_addr  in  address_width  first word address; sampled when start is accepted.
- length  in  len_width  number of words to read; sampled when start is accepted.
- busy  out  1  high from the accepted start until the done pulse, inclusive.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- ram_addr  out  address_width  RAM port address (registered).
- ram_wr  out  1  RAM port write enable; constant 0.
- ram_din  out  data_width  RAM port write data; constant 0.
- ram_dout  in  data_width  RAM port read data; valid one cycle after the address.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream consumer ready.
- m_data  out  data_width  stream data.
- m_last  out  1  high with the final word of the transfer.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, m_valid=0, m_last=0, ram_addr=0, m_data=0; skid buffer empty; in-flight flag cleared. Reset mid-transfer aborts it; no done pulse is produced.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - start=1 with length>0: load addr=start_addr, issue_cnt=length, beat_cnt=length; go to ISSUE; busy=1 from the next cycle.
  - start=1 with length=0: go straight to FINISH; busy=1 for exactly one cycle, together with done.
- ISSUE:
  - A read issues in a cycle when (buffer occupancy + in-flight − pop this cycle) < 2.
  - On issue: ram_addr<=addr; in_flight<=1 the next cycle; addr increments with wrap (ram_size-1 → 0); issue_cnt decrements.
  - When issue_cnt reaches 0, go to DRAIN.
- Capture: in the cycle after an issue, ram_dout is pushed into the skid buffer. ram_addr holds its value between issues.
- Stream:
  - m_valid = buffer not empty; m_data = buffer head.
  - Pop on m_valid & m_ready; beat_cnt decrements on each pop.
  - m_last = m_valid & (beat_cnt==1).
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
- DRAIN: when beat_cnt hits 0 on a pop, go to FINISH.
- FINISH: done=1 for one cycle; return to IDLE.
- Latency: start accepted at edge N → first m_valid=1 after edge N+2 (first issue at N+1, capture at N+2).
- Throughput: 1 word/cycle with m_ready held high. The buffer never overflows under any m_ready pattern.
- Simultaneous events:
  - Push and pop in the same cycle leave occupancy unchanged.
  - start in the FINISH cycle is ignored; start is accepted only in IDLE.
- Write port safety: ram_wr and ram_din are tied 0 in every state, so this port never writes.

Decomposition:
- Package bram_stream_reader_pkg:
  - state enum (IDLE, ISSUE, DRAIN, FINISH);
  - localparam SKID_DEPTH=2;
  - function next_addr(addr, ram_size) implementing the wrap.
- Sub-module bram_rd_skid_fifo: 2-entry FIFO, parameterised by data_width, carrying data plus a last flag. Provides count, push, pop, empty and full.

Test Plan:
- start_addr=0x010, length=4, m_ready=1, RAM prefilled mem[i]=i → m_data=0x10..0x13 on consecutive cycles; m_last on 0x13; first m_valid 2 cycles after start; done 1 cycle after the last beat.
- start_addr=510, length=4, ram_size=512 → words from addresses 510, 511, 0, 1, in order.
- length=4, m_ready toggling 1,0,0,1,0,1,1 → exactly 4 beats, no duplicates or drops; m_data stable during every stall.
- length=0 → no m_valid; busy and done high together for one cycle.
- start pulsed again mid-transfer with different start_addr and length → ignored; the original 4 words are delivered unchanged.
- rst_n asserted after 2 of 8 beats → all outputs at reset values immediately; no done; a new start with length=2 then completes correctly.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// Shared types and helpers for the BRAM stream reader.
//   state_e    : controller states
//   SKID_DEPTH : entries in the read-latency skid buffer
//   next_addr  : sequential address step with wrap at ram_size
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } state_e;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_PTR_W = $clog2(SKID_DEPTH);
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  function automatic int unsigned next_addr(input int unsigned addr, input int unsigned ram_size);
    return (addr >= ram_size - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready output stream of the BRAM stream reader.
//   m_valid : word valid (master -> slave)
//   m_ready : consumer ready (slave -> master)
//   m_data  : word
//   m_last  : final word of the transfer
interface bram_stream_reader_if #(
  parameter int unsigned data_width = 72
);
  logic                  m_valid;
  logic                  m_ready;
  logic [data_width-1:0] m_data;
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/bram_rd_skid_fifo.sv
// Two-entry FIFO that absorbs the RAM read latency (data plus last flag).
//   clk, rst_n                : clock, async active-low reset
//   push_i/push_data_i/_last_i: write side
//   pop_i                     : remove head (ignored when empty)
//   head_data_o/head_last_o   : current head entry
//   count_o, empty_o, full_o  : occupancy
module bram_rd_skid_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned data_width = 72
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [data_width-1:0] push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic [data_width-1:0] head_data_o,
  output logic                  head_last_o,
  output logic [SKID_CNT_W-1:0] count_o,
  output logic                  empty_o,
  output logic                  full_o
);

  logic [data_width-1:0] data_q [SKID_DEPTH];
  logic [SKID_DEPTH-1:0] last_q;
  logic [SKID_PTR_W-1:0] wr_q, rd_q;
  logic [SKID_CNT_W-1:0] cnt_q;
  logic                  do_push, do_pop;

  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == SKID_CNT_W'(SKID_DEPTH));
  assign count_o     = cnt_q;
  assign head_data_o = data_q[rd_q];
  assign head_last_o = last_q[rd_q];

  // A push into a full buffer is only safe when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) data_q[i] <= '0;
      last_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        data_q[wr_q] <= push_data_i;
        last_q[wr_q] <= push_last_i;
        wr_q         <= wr_q + SKID_PTR_W'(1);
      end
      if (do_pop) rd_q <= rd_q + SKID_PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + SKID_CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - SKID_CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side client for one BRAM port: on start, reads `length` words from
// `start_addr` (wrapping at ram_size) and emits them on a valid/ready stream.
//   clk, rst_n         : clock, async active-low reset
//   start/start_addr/length : command (accepted only in IDLE)
//   busy, done         : status; done pulses once after the last beat
//   ram_addr/ram_wr/ram_din/ram_dout : RAM port (read only, 1-cycle latency)
//   m                  : output stream (bram_stream_reader_if.master)
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned data_width    = 72,
  parameter int unsigned address_width = 10,
  parameter int unsigned ram_size      = 512,
  parameter int unsigned len_width     = address_width + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [address_width-1:0] start_addr,
  input  logic [len_width-1:0]     length,
  output logic                     busy,
  output logic                     done,
  output logic [address_width-1:0] ram_addr,
  output logic                     ram_wr,
  output logic [data_width-1:0]    ram_din,
  input  logic [data_width-1:0]    ram_dout,
  bram_stream_reader_if.master     m
);

  state_e                   state_q, state_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [address_width-1:0] ram_addr_q, ram_addr_d;
  logic [len_width-1:0]     issue_cnt_q, issue_cnt_d;
  logic [len_width-1:0]     beat_cnt_q, beat_cnt_d;
  logic                     in_flight_q, in_flight_d;
  logic                     flight_last_q, flight_last_d;

  logic                     fifo_empty, fifo_full, fifo_last;
  logic [SKID_CNT_W-1:0]    fifo_count;
  logic [data_width-1:0]    fifo_data;
  logic                     pop, slot_free, can_issue;

  bram_rd_skid_fifo #(
    .data_width(data_width)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (in_flight_q),
    .push_data_i(ram_dout),
    .push_last_i(flight_last_q),
    .pop_i      (pop),
    .head_data_o(fifo_data),
    .head_last_o(fifo_last),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign m.m_valid = !fifo_empty;
  assign m.m_data  = fifo_data;
  assign m.m_last  = !fifo_empty && fifo_last;
  assign pop       = !fifo_empty && m.m_ready;

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign ram_addr = ram_addr_q;
  assign ram_wr   = 1'b0;
  assign ram_din  = '0;

  // Reads in flight count as occupied slots so a stalled consumer can never
  // overrun the two-entry buffer; slot_free is implied by the occupancy term
  // but kept as a direct guard.
  assign slot_free = !fifo_full || pop;
  assign can_issue = slot_free &&
                     ((32'(fifo_count) + 32'(in_flight_q) - 32'(pop)) < SKID_DEPTH);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    ram_addr_d    = ram_addr_q;
    issue_cnt_d   = issue_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    in_flight_d   = 1'b0;
    flight_last_d = flight_last_q;

    if (pop) beat_cnt_d = beat_cnt_q - len_width'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d      = start_addr;
            issue_cnt_d = length;
            beat_cnt_d  = length;
            state_d     = ISSUE;
          end else begin
            state_d = FINISH;
          end
        end
      end
      ISSUE: begin
        if (can_issue) begin
          ram_addr_d    = addr_q;
          in_flight_d   = 1'b1;
          flight_last_d = (issue_cnt_q == len_width'(1));
          addr_d        = address_width'(next_addr(32'(addr_q), ram_size));
          issue_cnt_d   = issue_cnt_q - len_width'(1);
          if (issue_cnt_q == len_width'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && beat_cnt_q == len_width'(1)) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      ram_addr_q    <= '0;
      issue_cnt_q   <= '0;
      beat_cnt_q    <= '0;
      in_flight_q   <= 1'b0;
      flight_last_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      ram_addr_q    <= ram_addr_d;
      issue_cnt_q   <= issue_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      in_flight_q   <= in_flight_d;
      flight_last_q <= flight_last_d;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: a queue-based reference model
// compared every cycle, plus directed literal checks and randomized transfers.
module tb_bram_stream_reader;
  localparam int unsigned DW = 72;
  localparam int unsigned AW = 10;
  localparam int unsigned RS = 512;
  localparam int unsigned LW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] length;
  logic          busy, done, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  bram_stream_reader_if #(.data_width(DW)) s_if ();

  bram_stream_reader #(
    .data_width   (DW),
    .address_width(AW),
    .ram_size     (RS),
    .len_width    (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_wr    (ram_wr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .m         (s_if.master)
  );

  always #5 clk = ~clk;

  // RAM port model: the registered ram_addr acts as the RAM's address
  // register, so data for an address appears one cycle after it is issued.
  logic [DW-1:0] mem [RS];
  assign ram_dout = mem[ram_addr[8:0]];

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  function automatic void chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endfunction

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          exp_q [$];
  logic [DW-1:0] seen_q[$];
  bit            model_busy   = 1'b0;
  bit            pending_done = 1'b0;
  int            beats_seen   = 0;
  bit            prev_stall   = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  // Reference model + per-cycle compare. Inputs change at posedge+1, so the
  // values seen here are what the DUT samples at the coming posedge.
  always @(negedge clk) begin
    bit       nb, nd;
    exp_t     e;
    logic [8:0] ix;
    if (!rst_n) begin
      exp_q.delete();
      model_busy   = 1'b0;
      pending_done = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      chk1("busy", busy, model_busy);
      chk1("done", done, pending_done);
      chk1("ram_wr", ram_wr, 1'b0);
      chk("ram_din", ram_din, '0);
      if (prev_stall) begin
        chk1("stall_valid", s_if.m_valid, 1'b1);
        chk("stall_data", s_if.m_data, prev_data);
        chk1("stall_last", s_if.m_last, prev_last);
      end
      if (s_if.m_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%h required=none", s_if.m_data);
        end else begin
          chk("m_data", s_if.m_data, exp_q[0].d);
          chk1("m_last", s_if.m_last, exp_q[0].l);
        end
      end
      nb = model_busy;
      nd = 1'b0;
      if (pending_done) nb = 1'b0;
      if (!model_busy && start) begin
        nb = 1'b1;
        if (length == '0) nd = 1'b1;
        else begin
          for (int k = 0; k < int'(length); k++) begin
            ix = 9'((int'(start_addr) + k) % RS);
            exp_q.push_back('{d: mem[ix], l: (k == int'(length) - 1)});
          end
        end
      end
      if (s_if.m_valid && s_if.m_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        seen_q.push_back(s_if.m_data);
        beats_seen++;
        if (e.l) nd = 1'b1;
      end
      prev_stall   = s_if.m_valid && !s_if.m_ready;
      prev_data    = s_if.m_data;
      prev_last    = s_if.m_last;
      model_busy   = nb;
      pending_done = nd;
    end
  end

  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic run_xfer(input int sa, input int len, input int mode, input int spur_at);
    bit fin;
    fin = 1'b0;
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = AW'(sa);
    length     = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!model_busy) begin
        fin = 1'b1;
        break;
      end
      case (mode)
        0:       s_if.m_ready = 1'b1;
        1:       s_if.m_ready = ($urandom % 3 != 0);
        default: s_if.m_ready = pat[cyc % 7];
      endcase
      start = 1'b0;
      if (cyc == spur_at) begin
        start      = 1'b1;
        start_addr = AW'(256);
        length     = LW'(7);
      end
      if (mode == 1 && ($urandom % 7) == 0) begin
        start      = 1'b1;
        start_addr = AW'($urandom % RS);
        length     = LW'($urandom % 9);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk1("xfer_finished", fin, 1'b1);
    chk("queue_drained", DW'(exp_q.size()), '0);
  endtask

  // With mem[i]=i the words seen must be first, first+1, ... wrapping at RS.
  task automatic chk_run(input string nm, input int first, input int n);
    chk({nm, "_count"}, DW'(seen_q.size()), DW'(n));
    for (int k = 0; k < n && k < seen_q.size(); k++)
      chk({nm, "_word"}, seen_q[k], DW'((first + k) % RS));
  endtask

  task automatic chk_rst_outputs(input string nm);
    chk1({nm, "_busy"}, busy, 1'b0);
    chk1({nm, "_done"}, done, 1'b0);
    chk1({nm, "_valid"}, s_if.m_valid, 1'b0);
    chk1({nm, "_last"}, s_if.m_last, 1'b0);
    chk({nm, "_ram_addr"}, DW'(ram_addr), '0);
    chk({nm, "_m_data"}, s_if.m_data, '0);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    start_addr   = '0;
    length       = '0;
    s_if.m_ready = 1'b0;
    for (int i = 0; i < RS; i++) mem[i] = DW'(i);
    #12;
    chk_rst_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Latency / throughput / last / done timing with hand-computed values.
    @(posedge clk); #1;
    start = 1'b1; start_addr = AW'(16); length = LW'(4); s_if.m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk1("lat_valid_n0", s_if.m_valid, 1'b0);
    chk1("lat_busy_n0", busy, 1'b1);
    @(negedge clk);
    chk1("lat_valid_n1", s_if.m_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("seq_valid", s_if.m_valid, 1'b1);
      chk("seq_data", s_if.m_data, DW'(16 + k));
      chk1("seq_last", s_if.m_last, k == 3);
      chk1("seq_done", done, 1'b0);
    end
    @(negedge clk);
    chk1("seq_done_pulse", done, 1'b1);
    chk1("seq_busy_at_done", busy, 1'b1);
    chk1("seq_valid_after", s_if.m_valid, 1'b0);
    @(negedge clk);
    chk1("seq_idle_busy", busy, 1'b0);
    chk1("seq_idle_done", done, 1'b0);

    // Zero-length command.
    @(posedge clk); #1;
    start = 1'b1; start_addr = AW'(5); length = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk1("len0_busy", busy, 1'b1);
    chk1("len0_done", done, 1'b1);
    chk1("len0_valid", s_if.m_valid, 1'b0);
    @(negedge clk);
    chk1("len0_busy_after", busy, 1'b0);
    chk1("len0_done_after", done, 1'b0);

    // Address wrap.
    seen_q.delete();
    run_xfer(510, 4, 0, -1);
    chk_run("wrap", 510, 4);

    // Backpressure pattern.
    seen_q.delete();
    run_xfer(48, 4, 2, -1);
    chk_run("toggle", 48, 4);

    // Start pulsed mid-transfer must be ignored.
    seen_q.delete();
    run_xfer(32, 4, 0, 1);
    chk_run("spur", 32, 4);

    // Reset after two of eight beats.
    seen_q.delete();
    beats_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = AW'(64); length = LW'(8); s_if.m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 20 && beats_seen < 2; cyc++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk_rst_outputs("midrst");
    chk_run("midrst", 64, 2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_q.delete();
    run_xfer(80, 2, 0, -1);
    chk_run("post_rst", 80, 2);

    // Randomized transfers against the model.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < RS; i++) mem[i] = {8'($urandom), $urandom, $urandom};
      run_xfer(int'($urandom % RS), ($urandom % 10 == 0) ? 512 : int'($urandom_range(0, 20)), 1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
